// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Payloads narrower than 9 bits are zero-extended; zeros do not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and pulses bit_end_o on the last one.
module uart_baud_gen #(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == CntMax);

  // Next count: held at zero while restarted, wraps at every bit boundary.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (restart_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with run-time parity and stop-bit selection, latched per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d;
  logic              stop2_q, stop2_d;
  logic              tx_out_q, tx_out_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign tx_ready = (state_q == StIdle);
  assign busy     = ~tx_ready;
  assign tx_out   = tx_out_q;
  assign done     = done_q;

  // Timer is held in restart while idle so the start bit always gets a full period.
  uart_baud_gen #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(tx_ready),
    .bit_end_o(bit_end)
  );

  // Next-state, frame latching and line-level decode.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;

    case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d    = StStart;
          shift_d    = tx_data;
          idx_d      = '0;
          par_en_d   = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          par_bit_d  = calc_parity(9'(tx_data), parity_mode == PAR_ODD);
          two_stop_d = two_stop;
          stop2_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxLast) begin
            state_d = par_en_q ? StParity : StStop;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is decoded from the next state so tx_out can be a plain flop.
    case (state_d)
      StStart:  tx_out_d = 1'b0;
      StData:   tx_out_d = shift_d[0];
      StParity: tx_out_d = par_bit_q;
      default:  tx_out_d = 1'b1;
    endcase

    done_d = (state_q == StStop) && (state_d == StIdle);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      tx_out_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      tx_out_q   <= tx_out_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg (DATA_W=8, CLKS_PER_BIT=4).
module tb_uart_tx_cfg;
  import uart_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic cap_line [1:127];
  int   done_cnt;
  int   first_done;
  int   second_done;

  uart_tx_cfg #(
    .DATA_W      (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .tx_out     (tx_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout, required finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Present a frame at a negedge; returns just after the accepting posedge.
  task automatic start(input logic [7:0] d, input logic [1:0] m, input logic ts,
                       input logic keep_valid);
    @(negedge clk);
    check_eq("ready_pre", 32'(tx_ready), 32'd1);
    tx_data     = d;
    parity_mode = m;
    two_stop    = ts;
    tx_valid    = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) tx_valid = 1'b0;
  endtask

  // Sample tx_out/done at negedge of cycles 1..ncyc after acceptance.
  task automatic capture(input int ncyc, input int drop_at, input int dist_at);
    done_cnt    = 0;
    first_done  = -1;
    second_done = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cap_line[k] = tx_out;
      if (done) begin
        done_cnt++;
        check_eq("ready_at_done", 32'(tx_ready), 32'd1);
        if (first_done < 0) first_done = k;
        else if (second_done < 0) second_done = k;
      end
      if (k == 2) begin
        check_eq("busy_mid", 32'(busy), 32'd1);
        check_eq("ready_mid", 32'(tx_ready), 32'd0);
      end
      if (k == drop_at) tx_valid = 1'b0;
      if (dist_at > 0 && k == dist_at) begin
        tx_data     = ~tx_data;
        parity_mode = PAR_ODD;
        two_stop    = ~two_stop;
        tx_valid    = 1'b1;
      end
      if (dist_at > 0 && k == dist_at + 1) tx_valid = 1'b0;
    end
  endtask

  // Each slot must hold its expected level for all four cycles.
  task automatic check_slots(input string tag, input int base, input logic [0:15] e,
                             input int nslots);
    logic [3:0] got;
    for (int s = 0; s < nslots; s++) begin
      got = {cap_line[base + 4*s + 3], cap_line[base + 4*s + 2],
             cap_line[base + 4*s + 1], cap_line[base + 4*s]};
      check_eq($sformatf("%s_slot%0d", tag, s), 32'(got), 32'({4{e[s]}}));
    end
  endtask

  task automatic run_std(input string tag, input logic [7:0] d, input logic [1:0] m,
                         input logic ts, input logic [0:15] e, input int nslots,
                         input int dist_at);
    start(d, m, ts, 1'b0);
    capture(nslots*4 + 6, -1, dist_at);
    check_slots(tag, 1, e, nslots);
    check_eq({tag, "_done_at"}, 32'(first_done), 32'(nslots*4 + 1));
    check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_idle_after"}, 32'(cap_line[nslots*4 + 1]), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    parity_mode = PAR_NONE;
    two_stop    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_out", 32'(tx_out), 32'd1);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_tx_out", 32'(tx_out), 32'd1);

    // Slot vectors: start, data LSB first, [parity], stop(s); trailing ones are padding.
    run_std("a5_none",  8'hA5, PAR_NONE, 1'b0, 16'b0101001011_111111, 10, 0);
    run_std("07_even",  8'h07, PAR_EVEN, 1'b0, 16'b01110000011_11111, 11, 0);
    run_std("07_odd",   8'h07, PAR_ODD,  1'b0, 16'b01110000001_11111, 11, 0);
    run_std("07_mode3", 8'h07, 2'b11,    1'b0, 16'b0111000001_111111, 10, 0);
    run_std("a5_2stop", 8'hA5, PAR_NONE, 1'b1, 16'b01010010111_11111, 11, 0);
    // Inputs flipped and tx_valid pulsed at cycle 10, mid-frame.
    run_std("5a_dist",  8'h5A, PAR_EVEN, 1'b0, 16'b00101101001_11111, 11, 10);

    // Back-to-back: valid held through the done cycle of the first frame.
    start(8'h55, PAR_NONE, 1'b0, 1'b1);
    tx_data = 8'hAA;
    capture(90, 42, 0);
    check_slots("b2b_55", 1, 16'b0101010101_111111, 10);
    check_eq("b2b_done1", 32'(first_done), 32'd41);
    check_eq("b2b_gap_hi", 32'(cap_line[41]), 32'd1);
    check_eq("b2b_start2", 32'(cap_line[42]), 32'd0);
    check_slots("b2b_aa", 42, 16'b0010101011_111111, 10);
    check_eq("b2b_done2", 32'(second_done), 32'd82);
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // Reset during data bit 3 (slot 4, cycles 17..20); 0xC3 bit 3 is 0.
    start(8'hC3, PAR_NONE, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    check_eq("pre_rst_bit3", 32'(tx_out), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx_out", 32'(tx_out), 32'd1);
    check_eq("midrst_ready", 32'(tx_ready), 32'd1);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_done", 32'(done), 32'd0);
    run_std("3c_after_rst", 8'h3C, PAR_NONE, 1'b0, 16'b0001111001_111111, 10, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
